// File: rtl/ecc_ram_secded.sv
// ecc_ram_secded -- word RAM protected by an extended Hamming SECDED code.
//
// Each word is stored as a CW-bit codeword: bit 0 holds even overall parity,
// check bits sit at positions 1,2,4,..., and data bits fill the remaining
// positions in ascending order, data LSB first. Reads correct single-bit
// errors, write the corrected word back, and flag double-bit errors.
//
// Ports:
//   clk, rst           sole clock (rising edge); synchronous active-high reset
//   req_valid/ready    request handshake; ready only in IDLE and not in reset
//   req_we             1 = write, 0 = read
//   req_addr/wdata     word address / write data
//   inj_mask           XORed into the codeword on write (error injection)
//   rsp_valid          one-cycle read response strobe, two cycles after accept
//   rsp_rdata          read data (corrected when correctable, raw on DBE)
//   rsp_sbe/rsp_dbe    corrected-single / detected-double flags
//   sbe_count/dbe_count saturating 16-bit error counters
//
// Optional feature: define ECC_RAM_SCRUB_EN to build the background scrubber,
// which reads and repairs one word after SCRUB_IDLE idle cycles.
//
// state     | meaning
// ST_IDLE   | accepting requests; writes complete here
// ST_RD     | host read codeword registered, decode and respond
// ST_WB     | write corrected codeword back after a host SBE
// ST_SCR_RD | scrub read codeword registered, decode and count
// ST_SCR_WB | write corrected codeword back after a scrub SBE
module ecc_ram_secded #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int SCRUB_IDLE = 16,
  // smallest r with 2**r >= DATA_WIDTH + r + 1, for the legal 4..64 range
  localparam int R  = (DATA_WIDTH <= 4)  ? 3 :
                      (DATA_WIDTH <= 11) ? 4 :
                      (DATA_WIDTH <= 26) ? 5 :
                      (DATA_WIDTH <= 57) ? 6 : 7,
  localparam int CW = DATA_WIDTH + R + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [CW-1:0]         inj_mask,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_sbe,
  output logic                  rsp_dbe,
  output logic [15:0]           sbe_count,
  output logic [15:0]           dbe_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Out-of-range configurations elaborate this empty marker block.
  if (DATA_WIDTH < 4 || DATA_WIDTH > 64 || SCRUB_IDLE < 1) begin : g_param_range_violated
  end

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WB, ST_SCR_RD, ST_SCR_WB} state_e;

  function automatic logic [CW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
    logic [CW-1:0] cw;
    int di;
    cw = '0;
    di = 0;
    for (int p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[di];
        di++;
      end
    end
    for (int k = 0; k < R; k++) begin
      for (int p = 3; p < CW; p++) begin
        if (((p >> k) & 1) != 0 && (p & (p - 1)) != 0) cw[1 << k] = cw[1 << k] ^ cw[p];
      end
    end
    cw[0] = ^cw[CW-1:1];
    return cw;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extract(input logic [CW-1:0] cw);
    logic [DATA_WIDTH-1:0] d;
    int di;
    d  = '0;
    di = 0;
    for (int p = 3; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[di] = cw[p];
        di++;
      end
    end
    return d;
  endfunction

  logic [CW-1:0]         mem_q [DEPTH];
  state_e                state_q;
  logic [CW-1:0]         cw_q;
  logic [CW-1:0]         corr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rsp_valid_q, rsp_sbe_q, rsp_dbe_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [15:0]           sbe_cnt_q, dbe_cnt_q;

`ifdef ECC_RAM_SCRUB_EN
  localparam int IW = $clog2(SCRUB_IDLE + 1);
  localparam logic [IW-1:0] IDLE_TC = IW'(SCRUB_IDLE - 1);
  logic [IW-1:0]         idle_cnt_q;
  logic [ADDR_WIDTH-1:0] scrub_addr_q;
`endif

  logic [R-1:0]          syn;
  logic                  perr, dec_sbe, dec_dbe;
  logic [CW-1:0]         dec_cw;
  logic [DATA_WIDTH-1:0] dec_data;

  // Syndrome is the XOR of the positions of all set bits; a single flip at
  // position p leaves syndrome p with the overall parity broken.
  always_comb begin
    syn = '0;
    for (int p = 1; p < CW; p++) begin
      if (cw_q[p]) syn = syn ^ R'(p);
    end
    perr    = ^cw_q;
    dec_sbe = perr && (32'(syn) < CW);
    dec_dbe = (perr || syn != '0) && !dec_sbe;
    dec_cw  = cw_q;
    if (dec_sbe) dec_cw[syn] = ~cw_q[syn];
    // on DBE dec_cw equals the raw word, so rdata is the raw data bits
    dec_data = extract(dec_cw);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_sbe_q   <= 1'b0;
      rsp_dbe_q   <= 1'b0;
      sbe_cnt_q   <= '0;
      dbe_cnt_q   <= '0;
`ifdef ECC_RAM_SCRUB_EN
      idle_cnt_q   <= '0;
      scrub_addr_q <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_sbe_q   <= 1'b0;
      rsp_dbe_q   <= 1'b0;
      if (state_q == ST_RD || state_q == ST_SCR_RD) begin
        if (dec_sbe && sbe_cnt_q != 16'hFFFF) sbe_cnt_q <= sbe_cnt_q + 16'd1;
        if (dec_dbe && dbe_cnt_q != 16'hFFFF) dbe_cnt_q <= dbe_cnt_q + 16'd1;
      end
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
`ifdef ECC_RAM_SCRUB_EN
            idle_cnt_q <= '0;
`endif
            if (!req_we) begin
              addr_q  <= req_addr;
              cw_q    <= mem_q[req_addr];
              state_q <= ST_RD;
            end
          end
`ifdef ECC_RAM_SCRUB_EN
          else if (idle_cnt_q == IDLE_TC) begin
            idle_cnt_q <= '0;
            addr_q     <= scrub_addr_q;
            cw_q       <= mem_q[scrub_addr_q];
            state_q    <= ST_SCR_RD;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
`endif
        end
        ST_RD: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= dec_data;
          rsp_sbe_q   <= dec_sbe;
          rsp_dbe_q   <= dec_dbe;
          if (dec_sbe) begin
            corr_q  <= dec_cw;
            state_q <= ST_WB;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WB: state_q <= ST_IDLE;
`ifdef ECC_RAM_SCRUB_EN
        ST_SCR_RD: begin
          scrub_addr_q <= scrub_addr_q + 1'b1;
          if (dec_sbe) begin
            corr_q  <= dec_cw;
            state_q <= ST_SCR_WB;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SCR_WB: state_q <= ST_IDLE;
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Storage is never cleared by reset; reset only blocks writes at its edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_IDLE && req_valid && req_we)
        mem_q[req_addr] <= encode(req_wdata) ^ inj_mask;
      else if (state_q == ST_WB || state_q == ST_SCR_WB)
        mem_q[addr_q] <= corr_q;
    end
  end

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_sbe   = rsp_sbe_q;
  assign rsp_dbe   = rsp_dbe_q;
  assign sbe_count = sbe_cnt_q;
  assign dbe_count = dbe_cnt_q;

endmodule

// File: tb/tb_ecc_ram_secded.sv
// Bench for ecc_ram_secded at default parameters (8 data bits, 13-bit codeword).
module tb_ecc_ram_secded;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 13;
  localparam int SCRUB_IDLE = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [CW-1:0] inj_mask;
  logic          rsp_valid, rsp_sbe, rsp_dbe;
  logic [DW-1:0] rsp_rdata;
  logic [15:0]   sbe_count, dbe_count;

  always #5 clk = ~clk;

  ecc_ram_secded #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SCRUB_IDLE(SCRUB_IDLE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .inj_mask(inj_mask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_sbe(rsp_sbe), .rsp_dbe(rsp_dbe),
    .sbe_count(sbe_count), .dbe_count(dbe_count)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_data [16];
  logic [CW-1:0] m_mask [16];
  int m_sbe, m_dbe;

  // codeword position holding data bit i (non-powers-of-two from 3 upward)
  function automatic int data_pos(input int i);
    int c, res;
    c = 0;
    res = 0;
    for (int p = 3; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (c == i) res = p;
        c++;
      end
    end
    return res;
  endfunction

  function automatic logic [DW-1:0] raw_data(input logic [DW-1:0] d, input logic [CW-1:0] m);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = d[i] ^ m[data_pos(i)];
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [CW-1:0] m);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; inj_mask = m;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wr ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; inj_mask = '0;
  endtask

  task automatic do_read(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] ed,
                         input logic es, input logic edb);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({nm, " ready"}, req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check({nm, " early rsp_valid"}, rsp_valid, 0);
    @(negedge clk);
    check({nm, " rsp_valid"}, rsp_valid, 1);
    check({nm, " rdata"}, rsp_rdata, ed);
    check({nm, " sbe"}, rsp_sbe, es);
    check({nm, " dbe"}, rsp_dbe, edb);
    check({nm, " ready during wb"}, req_ready, !es);
    @(negedge clk);
    check({nm, " late rsp_valid"}, rsp_valid, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [CW-1:0] mask;
    logic [DW-1:0] rdata;
    logic          sbe;
    logic          dbe;
    logic [15:0]   sc;
    logic [15:0]   dc;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d, ed;
    logic [CW-1:0] m;
    logic          es, edb, seen;
    int            p1, p2, pc;

    tbl[0]  = '{1'b1, 4'd3,  8'hA5, 13'h0000, 8'h00, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[1]  = '{1'b0, 4'd3,  8'h00, 13'h0000, 8'hA5, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[2]  = '{1'b1, 4'd7,  8'h3C, 13'h0040, 8'h00, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[3]  = '{1'b0, 4'd7,  8'h00, 13'h0000, 8'h3C, 1'b1, 1'b0, 16'd1, 16'd0};
    tbl[4]  = '{1'b0, 4'd7,  8'h00, 13'h0000, 8'h3C, 1'b0, 1'b0, 16'd1, 16'd0};
    tbl[5]  = '{1'b1, 4'd2,  8'h5A, 13'h0208, 8'h00, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[6]  = '{1'b0, 4'd2,  8'h00, 13'h0000, 8'h4B, 1'b0, 1'b1, 16'd1, 16'd1};
    tbl[7]  = '{1'b0, 4'd2,  8'h00, 13'h0000, 8'h4B, 1'b0, 1'b1, 16'd1, 16'd2};
    tbl[8]  = '{1'b1, 4'd5,  8'hFF, 13'h0001, 8'h00, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[9]  = '{1'b0, 4'd5,  8'h00, 13'h0000, 8'hFF, 1'b1, 1'b0, 16'd2, 16'd2};
    tbl[10] = '{1'b1, 4'd0,  8'h00, 13'h1000, 8'h00, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[11] = '{1'b0, 4'd0,  8'h00, 13'h0000, 8'h00, 1'b1, 1'b0, 16'd3, 16'd2};
    tbl[12] = '{1'b1, 4'd15, 8'h81, 13'h0006, 8'h00, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[13] = '{1'b0, 4'd15, 8'h00, 13'h0000, 8'h81, 1'b0, 1'b1, 16'd3, 16'd3};
    tbl[14] = '{1'b0, 4'd3,  8'h00, 13'h0000, 8'hA5, 1'b0, 1'b0, 16'd3, 16'd3};
    tbl[15] = '{1'b0, 4'd5,  8'h00, 13'h0000, 8'hFF, 1'b0, 1'b0, 16'd3, 16'd3};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; inj_mask = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset req_ready", req_ready, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_rdata", rsp_rdata, 0);
    check("reset rsp_sbe", rsp_sbe, 0);
    check("reset rsp_dbe", rsp_dbe, 0);
    check("reset sbe_count", sbe_count, 0);
    check("reset dbe_count", dbe_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // directed vectors
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].we) begin
        do_write(tbl[i].addr, tbl[i].wdata, tbl[i].mask);
      end else begin
        do_read($sformatf("vec%0d", i), tbl[i].addr, tbl[i].rdata, tbl[i].sbe, tbl[i].dbe);
        check($sformatf("vec%0d sbe_count", i), sbe_count, tbl[i].sc);
        check($sformatf("vec%0d dbe_count", i), dbe_count, tbl[i].dc);
      end
    end

    // saturation: preload the counter near the top, then produce three SBEs
    @(negedge clk);
    force dut.sbe_cnt_q = 16'hFFFD;
    #1 release dut.sbe_cnt_q;
    for (int k = 0; k < 3; k++) begin
      do_write(4'd5, 8'hFF, 13'h0001);
      do_read($sformatf("sat%0d", k), 4'd5, 8'hFF, 1'b1, 1'b0);
      check($sformatf("sat%0d sbe_count", k), sbe_count, (k == 0) ? 16'hFFFE : 16'hFFFF);
    end
    check("sat dbe_count", dbe_count, 16'd3);

    // reset one cycle after read acceptance aborts the read
    do_write(4'd9, 8'h77, 13'h0020);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
    check("abort rd ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort rd rsp_valid", rsp_valid, 0);
    check("abort rd req_ready", req_ready, 0);
    check("abort rd rdata", rsp_rdata, 0);
    check("abort rd sbe_count", sbe_count, 0);
    check("abort rd dbe_count", dbe_count, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort rd rsp_valid after", rsp_valid, 0);

    // reset during writeback leaves the error in memory
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort wb rsp_valid", rsp_valid, 1);
    check("abort wb sbe", rsp_sbe, 1);
    check("abort wb rdata", rsp_rdata, 8'h77);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort wb sbe_count", sbe_count, 0);
    @(negedge clk);
    do_read("post abort 1", 4'd9, 8'h77, 1'b1, 1'b0);
    check("post abort sbe_count", sbe_count, 1);
    do_read("post abort 2", 4'd9, 8'h77, 1'b0, 1'b0);
    do_read("post abort addr3", 4'd3, 8'hA5, 1'b0, 1'b0);

    // randomized traffic against the model
    pulse_reset();
    m_sbe = 0;
    m_dbe = 0;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      do_write(4'(i), d, '0);
      m_data[i] = d;
      m_mask[i] = '0;
    end
    for (int it = 0; it < 250; it++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d  = 8'($urandom);
        m  = '0;
        pc = $urandom_range(0, 2);
        p1 = $urandom_range(0, CW - 1);
        p2 = (p1 + $urandom_range(1, CW - 1)) % CW;
        if (pc >= 1) m[p1] = 1'b1;
        if (pc == 2) m[p2] = 1'b1;
        do_write(a, d, m);
        m_data[a] = d;
        m_mask[a] = m;
      end else begin
        pc = $countones(m_mask[a]);
        es = (pc == 1);
        edb = (pc == 2);
        ed = edb ? raw_data(m_data[a], m_mask[a]) : m_data[a];
        do_read($sformatf("rnd%0d", it), a, ed, es, edb);
        if (es) begin
          m_mask[a] = '0;
          if (m_sbe < 16'hFFFF) m_sbe++;
        end
        if (edb && m_dbe < 16'hFFFF) m_dbe++;
        check($sformatf("rnd%0d sbe_count", it), sbe_count, 64'(m_sbe));
        check($sformatf("rnd%0d dbe_count", it), dbe_count, 64'(m_dbe));
      end
    end

`ifdef ECC_RAM_SCRUB_EN
    // background scrub repairs address 0 without a host response
    pulse_reset();
    for (int i = 0; i < 16; i++) do_write(4'(i), 8'(i * 3), '0);
    do_write(4'd0, 8'h11, 13'h0400);
    seen = 1'b0;
    for (int c = 0; c < SCRUB_IDLE + 3; c++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("scrub rsp_valid seen", seen, 0);
    check("scrub sbe_count", sbe_count, 1);
    do_read("scrub host read", 4'd0, 8'h11, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ecc_ram_secded.md
ECC_RAM_SECDED -- requirements
Module: ecc_ram_secded

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per word (legal 4..64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter SCRUB_IDLE, default 16, idle cycles before a scrub read (legal >=1).
REQ-004 SHALL derive R = smallest r with 2**r >= DATA_WIDTH+r+1, and CW = DATA_WIDTH+R+1 (R=4, CW=13 at default).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request accepted when req_valid and req_ready both high.
REQ-009 req_we  in  1  1=write, 0=read.
REQ-010 req_addr  in  ADDR_WIDTH  word address.
REQ-011 req_wdata  in  DATA_WIDTH  write data.
REQ-012 inj_mask  in  CW  error-injection mask, XORed into the codeword on write.
REQ-013 rsp_valid  out  1  one-cycle read-response strobe.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data (corrected when correctable).
REQ-015 rsp_sbe / rsp_dbe  out  1 each  single-bit corrected / double-bit detected, valid with rsp_valid.
REQ-016 sbe_count / dbe_count  out  16 each  saturating error counters.

Function
REQ-017 Codeword SHALL be extended Hamming SECDED: bit 0 = even overall parity of bits 1..CW-1; check bits at power-of-two positions 1,2,4,..; data bits fill remaining positions ascending, data LSB first.
REQ-018 FSM states SHALL be IDLE, RD, WB, SCR_RD, SCR_WB; req_ready = 1 only in IDLE and not in reset.
REQ-019 Accepted write at edge T SHALL store encode(req_wdata) XOR inj_mask at edge T; no response; FSM stays IDLE.
REQ-020 Accepted read at edge T SHALL register the stored codeword (RD), decode it, and drive rsp_valid=1 with rdata/flags for exactly the cycle after edge T+1 (latency 2).
REQ-021 Decode: syndrome 0 and parity OK -> clean; parity error (any syndrome < CW) -> SBE, flip indicated bit (syndrome 0 = parity bit); syndrome != 0 with parity OK, or syndrome >= CW -> DBE.
REQ-022 On DBE, rsp_rdata SHALL be the raw stored data bits, and no writeback occurs.
REQ-023 On SBE, FSM SHALL enter WB for one cycle and write the corrected codeword to the same address, then IDLE; otherwise RD returns directly to IDLE.
REQ-024 Each SBE/DBE (host or scrub) SHALL increment its counter by 1, holding at 16'hFFFF.
REQ-025 req_valid low in IDLE SHALL not drop any state; request fields are sampled only at acceptance.

Reset
REQ-026 rst high at an edge SHALL force IDLE, req_ready=0 during that cycle, rsp_valid=0, rsp_rdata=0, rsp_sbe=0, rsp_dbe=0, both counters=0, scrub address=0, idle counter=0.
REQ-027 Reset mid-read or mid-WB SHALL abort: no response, no writeback; memory contents SHALL NOT be cleared.

Configuration
REQ-028 Macro ECC_RAM_SCRUB_EN SHALL compile in the background scrubber; without it SCR_RD/SCR_WB are unreachable and no idle counter exists.
REQ-029 With ECC_RAM_SCRUB_EN: after SCRUB_IDLE consecutive IDLE cycles with req_valid low, FSM SHALL read the scrub address (SCR_RD, req_ready=0), correct/write back SBE via SCR_WB, count errors, produce no rsp_valid, increment scrub address wrapping 2**ADDR_WIDTH-1 -> 0, and reset the idle counter.
REQ-030 A req_valid arriving during a scrub SHALL wait until IDLE; any accepted request resets the idle counter.

Verification
REQ-031 Write 0xA5 to addr 3, mask 0; read addr 3 -> rsp_valid 2 cycles after acceptance, rdata 0xA5, sbe=0, dbe=0.
REQ-032 Write 0x3C addr 7 with inj_mask bit 6 set; read -> 0x3C, sbe=1, sbe_count=1, req_ready low one extra cycle; reread -> sbe=0.
REQ-033 Write 0x5A addr 2 with inj_mask bits 3 and 9; read -> dbe=1, sbe=0, dbe_count=1; reread -> dbe=1 again.
REQ-034 inj_mask bit 0 only, data 0xFF -> read 0xFF, sbe=1; 0x10000 SBEs -> sbe_count holds 0xFFFF.
REQ-035 Assert rst the cycle after read acceptance -> no rsp_valid, counters 0; stored data readable afterwards.
REQ-036 ECC_RAM_SCRUB_EN: inject 1-bit error addr 0, idle >=SCRUB_IDLE+3 cycles -> sbe_count=1, no rsp_valid; host read addr 0 -> sbe=0.
